// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Canonical bubble instruction (addi x0, x0, 0).
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Counters are sized for the largest legal buffer depth so one width
    // serves every parameterisation.
    localparam int MAX_FETCH_DEPTH = 8;
    localparam int FETCH_CNT_W     = $clog2(MAX_FETCH_DEPTH + 1);

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] IR;
        logic [31:0] PC;
        logic        valid;
    } if_id_t;

    // Sequential word address.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO holding fetched words until decode can take them.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [31:0]            din,
    output logic [FETCH_CNT_W-1:0] occ,
    output logic [31:0]            head
);

    localparam int                     PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]       LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);
    localparam logic [FETCH_CNT_W-1:0] DEPTH_CNT = FETCH_CNT_W'(DEPTH);
    localparam logic [FETCH_CNT_W-1:0] CNT_ONE   = FETCH_CNT_W'(1);

    logic [31:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [FETCH_CNT_W-1:0] occ_q, occ_d;
    logic                   do_push_s, do_pop_s;

    // Pointer increment with wrap for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_IDX) begin
            r = '0;
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    // Qualify push/pop (flush wins; a full buffer may push while popping) and compute next pointers.
    always_comb begin
        do_pop_s  = pop && (occ_q != '0) && !flush;
        do_push_s = push && !flush && ((occ_q != DEPTH_CNT) || do_pop_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_d = occ_q + CNT_ONE;
                2'b01:   occ_d = occ_q - CNT_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// absorption with bypass, branch redirect with stale-response dropping, and
// the IF/ID pipeline register.
module if_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_DEPTH = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        should_stall,
    input  logic        take_branch,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    localparam logic [FETCH_CNT_W:0]   DEPTH_CREDIT = (FETCH_CNT_W + 1)'(FETCH_DEPTH);
    localparam logic [FETCH_CNT_W-1:0] CNT_ONE      = FETCH_CNT_W'(1);

    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            deliver_pc_q, deliver_pc_d;
    logic [FETCH_CNT_W-1:0] outstanding_q, outstanding_d;
    logic [FETCH_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    if_id_t                 if_id_q, if_id_d;

    logic [FETCH_CNT_W-1:0] occ_s;
    logic [31:0]            head_s;
    logic [FETCH_CNT_W:0]   credit_used_s;
    logic                   req_valid_s, req_fire_s, rsp_keep_s;
    logic                   buf_push_s, buf_pop_s, buf_flush_s;

    fetch_buffer #(.DEPTH(FETCH_DEPTH)) u_fetch_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push_s),
        .pop   (buf_pop_s),
        .flush (buf_flush_s),
        .din   (imem_rsp_data),
        .occ   (occ_s),
        .head  (head_s)
    );

    // Words in flight plus words buffered may never exceed the buffer depth,
    // so every response is guaranteed a slot even while decode stalls.
    assign credit_used_s  = {1'b0, outstanding_q} + {1'b0, occ_s};
    assign req_valid_s    = !rst && !take_branch && (credit_used_s < DEPTH_CREDIT);
    assign req_fire_s     = req_valid_s && imem_req_ready;
    assign rsp_keep_s     = imem_rsp_valid && (drop_cnt_q == '0) && !take_branch;
    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;

    // Next-state for counters, buffer control and IF/ID; a branch overrides everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        deliver_pc_d  = deliver_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if_id_d       = if_id_q;
        buf_push_s    = 1'b0;
        buf_pop_s     = 1'b0;
        buf_flush_s   = 1'b0;
        if (take_branch) begin
            buf_flush_s  = 1'b1;
            fetch_pc_d   = branch_target;
            deliver_pc_d = branch_target;
            // Everything still in flight belongs to the wrong path.
            if (imem_rsp_valid) begin
                outstanding_d = outstanding_q - CNT_ONE;
                drop_cnt_d    = outstanding_q - CNT_ONE;
            end else begin
                outstanding_d = outstanding_q;
                drop_cnt_d    = outstanding_q;
            end
            if_id_d = '{IR: NOP_INST, PC: if_id_q.PC, valid: 1'b0};
        end else begin
            case ({req_fire_s, imem_rsp_valid})
                2'b10:   outstanding_d = outstanding_q + CNT_ONE;
                2'b01:   outstanding_d = outstanding_q - CNT_ONE;
                default: outstanding_d = outstanding_q;
            endcase
            if (req_fire_s) begin
                fetch_pc_d = pc_next(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (should_stall) begin
                buf_push_s = rsp_keep_s;
            end else if (occ_s != '0) begin
                buf_pop_s    = 1'b1;
                buf_push_s   = rsp_keep_s;
                if_id_d      = '{IR: head_s, PC: deliver_pc_q, valid: 1'b1};
                deliver_pc_d = pc_next(deliver_pc_q);
            end else if (rsp_keep_s) begin
                if_id_d      = '{IR: imem_rsp_data, PC: deliver_pc_q, valid: 1'b1};
                deliver_pc_d = pc_next(deliver_pc_q);
            end else begin
                if_id_d = '{IR: NOP_INST, PC: if_id_q.PC, valid: 1'b0};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            deliver_pc_q  <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            if_id_q       <= '{IR: NOP_INST, PC: 32'h0000_0000, valid: 1'b0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            if_id_q       <= if_id_d;
        end
    end

    assign if_id_IR         = if_id_q.IR;
    assign if_id_PC         = if_id_q.PC;
    assign if_id_valid_inst = if_id_q.valid;

endmodule
